mcu_debug_target: RTL and testbench

MCU_DEBUG_TARGET -- requirements
Module: mcu_debug_target

---
 rtl/mcu_debug_target_pkg.sv | 44 ++++
 rtl/db_target_mem.sv | 46 ++++
 rtl/mcu_debug_target.sv | 188 ++++++++++++++++++
 tb/tb_mcu_debug_target.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_debug_target_pkg.sv
// Shared types and constants for the MCU debug target.
// Holds the IDLE/BUSY state enum, the command decode enum and its priority decoder,
// and the fill value returned for faulting reads.
package mcu_debug_target_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PAUSE,
    CMD_RESUME,
    CMD_DBG_RESET,
    CMD_REG_RD,
    CMD_REG_WR,
    CMD_MEM_RD,
    CMD_MEM_WR
  } cmd_e;

  localparam logic [31:0] ERR_FILL = 32'hFFFF_FFFF;

  // Several qualifiers may arrive together; the earliest in this list wins.
  function automatic cmd_e decode_cmd(input logic pause,
                                      input logic resume,
                                      input logic dbg_reset,
                                      input logic reg_rd,
                                      input logic reg_wr,
                                      input logic mem_rd,
                                      input logic mem_wr);
    cmd_e c;
    if (pause)          c = CMD_PAUSE;
    else if (resume)    c = CMD_RESUME;
    else if (dbg_reset) c = CMD_DBG_RESET;
    else if (reg_rd)    c = CMD_REG_RD;
    else if (reg_wr)    c = CMD_REG_WR;
    else if (mem_rd)    c = CMD_MEM_RD;
    else if (mem_wr)    c = CMD_MEM_WR;
    else                c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/db_target_mem.sv
// Byte-addressable big-endian target memory with byte and word access.
// Ports: clk; we/byte_mode/addr/wdata write port (word writes use an aligned addr);
// rdata is a combinational read of addr in the same byte/word mode. Contents are never reset.
module db_target_mem #(
  parameter int MEM_SIZE_WORDS = 4096,
  localparam int AW = $clog2(4 * MEM_SIZE_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          byte_mode,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int MEM_BYTES = 4 * MEM_SIZE_WORDS;

  logic [7:0] mem [0:MEM_BYTES-1];

  // Byte lanes of the word containing addr; the most significant byte sits at the lowest address.
  logic [AW-1:0] b0, b1, b2, b3;
  assign b0 = {addr[AW-1:2], 2'b00};
  assign b1 = {addr[AW-1:2], 2'b01};
  assign b2 = {addr[AW-1:2], 2'b10};
  assign b3 = {addr[AW-1:2], 2'b11};

  always_ff @(posedge clk) begin
    if (we) begin
      if (byte_mode) begin
        mem[addr] <= wdata[7:0];
      end else begin
        mem[b0] <= wdata[31:24];
        mem[b1] <= wdata[23:16];
        mem[b2] <= wdata[15:8];
        mem[b3] <= wdata[7:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (byte_mode) rdata = {24'h0, mem[addr]};
    else           rdata = {mem[b0], mem[b1], mem[b2], mem[b3]};
  end

endmodule

// File: rtl/mcu_debug_target.sv
// Debug target model: accepts one command at a time from an MCU controller, stays busy
// for LATENCY cycles, then presents d_rd/error. Also models a free-running, pausable pc.
// Ports: clk, reset (sync, active-high); valid + qualifiers, mem_rw_byte, addr, d_in in;
// d_rd, mcu_busy, error, pc, paused out.
module mcu_debug_target
  import mcu_debug_target_pkg::*;
#(
  parameter int MEM_SIZE_WORDS = 4096,
  parameter int NUM_REGS       = 32,
  parameter int LATENCY        = 4,
  parameter int PC_STEP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        dbg_reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_rw_byte,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_rd,
  output logic        mcu_busy,
  output logic        error,
  output logic [31:0] pc,
  output logic        paused
);

  localparam int MEM_BYTES = 4 * MEM_SIZE_WORDS;
  localparam int AW        = $clog2(MEM_BYTES);
  localparam int RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SW        = (PC_STEP_CYCLES > 1) ? $clog2(PC_STEP_CYCLES) : 1;
  localparam logic [31:0] PC_MASK   = 32'(MEM_BYTES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(PC_STEP_CYCLES - 1);
  localparam logic [7:0]  BUSY_LOAD = 8'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [7:0]    busy_cnt;
  logic [SW-1:0] step_cnt;
  logic [31:0]   regs [NUM_REGS];

  cmd_e  cmd;
  logic  accept;
  logic  busy_done;

  logic [RW-1:0] reg_idx;
  logic          reg_oor;
  logic          mem_err;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  // Result of the accepted command, held until the busy window closes.
  logic          cmd_err, cmd_is_read;
  logic [31:0]   cmd_rdata;
  logic          pend_err, pend_is_read;
  logic [31:0]   pend_rdata;

  assign cmd       = decode_cmd(pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr);
  assign accept    = valid && (state_q == ST_IDLE);
  assign busy_done = (state_q == ST_BUSY) && (busy_cnt == 8'd0);
  assign mcu_busy  = (state_q == ST_BUSY);

  assign reg_idx = addr[RW-1:0];
  assign reg_oor = (addr >= 32'(NUM_REGS));
  assign mem_err = (addr >= 32'(MEM_BYTES)) || (!mem_rw_byte && (addr[1:0] != 2'b00));

  // A reset arriving with the command wins, so the write must not land.
  assign mem_we = accept && !reset && (cmd == CMD_MEM_WR) && !mem_err;

  db_target_mem #(
    .MEM_SIZE_WORDS(MEM_SIZE_WORDS)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .byte_mode (mem_rw_byte),
    .addr      (addr[AW-1:0]),
    .wdata     (d_in),
    .rdata     (mem_rdata)
  );

  always_comb begin
    cmd_err     = 1'b0;
    cmd_is_read = 1'b0;
    cmd_rdata   = '0;
    case (cmd)
      CMD_NONE:   cmd_err = 1'b1;
      CMD_REG_RD: begin
        cmd_is_read = 1'b1;
        if (reg_oor) begin
          cmd_err   = 1'b1;
          cmd_rdata = ERR_FILL;
        end else if (reg_idx != '0) begin
          cmd_rdata = regs[reg_idx];
        end
      end
      CMD_REG_WR: cmd_err = reg_oor;
      CMD_MEM_RD: begin
        cmd_is_read = 1'b1;
        cmd_err     = mem_err;
        cmd_rdata   = mem_err ? ERR_FILL : mem_rdata;
      end
      CMD_MEM_WR: cmd_err = mem_err;
      default: ;
    endcase
  end

  // Command FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid)     state_d = ST_BUSY;
      ST_BUSY: if (busy_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // busy_cnt counts down the remaining busy cycles after the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt     <= 8'd0;
      pend_err     <= 1'b0;
      pend_is_read <= 1'b0;
      pend_rdata   <= '0;
    end else if (accept) begin
      busy_cnt     <= BUSY_LOAD;
      pend_err     <= cmd_err;
      pend_is_read <= cmd_is_read;
      pend_rdata   <= cmd_rdata;
    end else if ((state_q == ST_BUSY) && (busy_cnt != 8'd0)) begin
      busy_cnt <= busy_cnt - 8'd1;
    end
  end

  // Results become visible on the same edge that drops mcu_busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_rd  <= '0;
      error <= 1'b0;
    end else if (busy_done) begin
      error <= pend_err;
      if (pend_is_read) d_rd <= pend_rdata;
    end
  end

  // Register file; entry 0 is never written so it always reads back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (accept && (cmd == CMD_REG_WR) && !reg_oor && (reg_idx != '0)) begin
      regs[reg_idx] <= d_in;
    end
  end

  // Program counter model. paused is sampled before the command updates it, so the
  // accept edge of pause/resume still follows the old run state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      step_cnt <= '0;
      paused   <= 1'b0;
    end else if (accept && (cmd == CMD_DBG_RESET)) begin
      pc       <= '0;
      step_cnt <= '0;
      paused   <= 1'b0;
    end else begin
      if (accept && (cmd == CMD_PAUSE))  paused <= 1'b1;
      if (accept && (cmd == CMD_RESUME)) paused <= 1'b0;
      if (!paused) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          pc       <= (pc + 32'd4) & PC_MASK;
        end else begin
          step_cnt <= step_cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mcu_debug_target.sv
module tb_mcu_debug_target;

  localparam int LAT = 4;

  // Qualifier bit order: {pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr}
  localparam logic [6:0] Q_NONE  = 7'b0000000;
  localparam logic [6:0] Q_PAUSE = 7'b1000000;
  localparam logic [6:0] Q_RES   = 7'b0100000;
  localparam logic [6:0] Q_DBGR  = 7'b0010000;
  localparam logic [6:0] Q_RRD   = 7'b0001000;
  localparam logic [6:0] Q_RWR   = 7'b0000100;
  localparam logic [6:0] Q_MRD   = 7'b0000010;
  localparam logic [6:0] Q_MWR   = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset, valid, mem_rw_byte;
  logic [6:0]  q;
  logic [31:0] addr, d_in;
  logic [31:0] d_rd, pc;
  logic        mcu_busy, error, paused;

  always #5 clk = ~clk;

  mcu_debug_target #(
    .MEM_SIZE_WORDS(4096),
    .NUM_REGS(32),
    .LATENCY(LAT),
    .PC_STEP_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .pause       (q[6]),
    .resume      (q[5]),
    .dbg_reset   (q[4]),
    .reg_rd      (q[3]),
    .reg_wr      (q[2]),
    .mem_rd      (q[1]),
    .mem_wr      (q[0]),
    .mem_rw_byte (mem_rw_byte),
    .addr        (addr),
    .d_in        (d_in),
    .d_rd        (d_rd),
    .mcu_busy    (mcu_busy),
    .error       (error),
    .pc          (pc),
    .paused      (paused)
  );

  typedef struct packed {
    logic        chk_len;
    logic        chk_drd;
    logic [31:0] drd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cur_drd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mcu_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (mcu_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: mcu_busy stuck high");
    end
  endtask

  // Drive one command for a single cycle; returns at the negedge after the accept edge.
  task automatic drive(input logic [6:0] qq, input logic byt, input logic [31:0] a,
                       input logic [31:0] d);
    valid = 1'b1; q = qq; mem_rw_byte = byt; addr = a; d_in = d;
    @(negedge clk);
    valid = 1'b0; q = Q_NONE; mem_rw_byte = 1'b0; addr = '0; d_in = '0;
  endtask

  task automatic issue(input logic [6:0] qq, input logic byt, input logic [31:0] a,
                       input logic [31:0] d, input logic chk_len, input logic chk_drd,
                       input logic [31:0] e_drd, input logic e_err);
    exp_t e;
    wait_idle();
    e.chk_len = chk_len; e.chk_drd = chk_drd; e.drd = e_drd; e.err = e_err;
    sb.push_back(e);
    drive(qq, byt, a, d);
  endtask

  task automatic rd(input logic [6:0] qq, input logic byt, input logic [31:0] a,
                    input logic [31:0] e_drd, input logic e_err);
    issue(qq, byt, a, 32'h0, 1'b1, 1'b1, e_drd, e_err);
    cur_drd = e_drd;
  endtask

  task automatic nr(input logic [6:0] qq, input logic byt, input logic [31:0] a,
                    input logic [31:0] d, input logic e_err);
    issue(qq, byt, a, d, 1'b1, 1'b1, cur_drd, e_err);
  endtask

  // Monitor: each falling edge of mcu_busy retires one scoreboard entry.
  logic prev_busy = 1'b0;
  int   busy_len  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (mcu_busy) begin
      busy_len++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_completion: got d_rd %h with empty scoreboard", d_rd);
      end else begin
        e = sb.pop_front();
        if (e.chk_len) chk("busy_len", 32'(busy_len), 32'(LAT));
        chk("error", {31'h0, error}, {31'h0, e.err});
        if (e.chk_drd) chk("d_rd", d_rd, e.drd);
      end
      busy_len = 0;
    end
    prev_busy = mcu_busy;
  end

  initial begin
    int n;
    reset = 1'b1; valid = 1'b0; q = Q_NONE; mem_rw_byte = 1'b0; addr = '0; d_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'h0, mcu_busy}, 32'h0);
    chk("rst_error",  {31'h0, error},    32'h0);
    chk("rst_d_rd",   d_rd,              32'h0);
    chk("rst_pc",     pc,                32'h0);
    chk("rst_paused", {31'h0, paused},   32'h0);
    reset = 1'b0;

    // Memory: big-endian words, byte lanes, alignment and range errors
    nr(Q_MWR, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    rd(Q_MRD, 1'b1, 32'h11, 32'h000000AD, 1'b0);
    rd(Q_MRD, 1'b0, 32'h12, 32'hFFFFFFFF, 1'b1);
    rd(Q_MRD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    nr(Q_MWR, 1'b1, 32'h13, 32'h00000055, 1'b0);
    rd(Q_MRD, 1'b0, 32'h10, 32'hDEADBE55, 1'b0);
    nr(Q_MWR, 1'b0, 32'h16, 32'h12345678, 1'b1);
    // A misaligned word write must leave the aligned word it overlaps untouched
    nr(Q_MWR, 1'b0, 32'h14, 32'h0A0B0C0D, 1'b0);
    nr(Q_MWR, 1'b0, 32'h16, 32'h12345678, 1'b1);
    rd(Q_MRD, 1'b0, 32'h14, 32'h0A0B0C0D, 1'b0);
    rd(Q_MRD, 1'b1, 32'h4000, 32'hFFFFFFFF, 1'b1);
    nr(Q_MWR, 1'b0, 32'h4000, 32'h11111111, 1'b1);
    nr(Q_MWR, 1'b1, 32'h3FFF, 32'hFFFFFFA5, 1'b0);
    rd(Q_MRD, 1'b1, 32'h3FFF, 32'h000000A5, 1'b0);
    nr(Q_NONE, 1'b0, 32'h0, 32'h0, 1'b1);

    // Registers
    nr(Q_RWR, 1'b0, 32'd0, 32'd5, 1'b0);
    rd(Q_RRD, 1'b0, 32'd0, 32'h0, 1'b0);
    nr(Q_RWR, 1'b0, 32'd3, 32'h1234, 1'b0);
    rd(Q_RRD, 1'b0, 32'd3, 32'h1234, 1'b0);
    issue(Q_RRD, 1'b0, 32'd32, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    rd(Q_RRD, 1'b0, 32'd3, 32'h1234, 1'b0);

    // Priority: reg_rd beats mem_wr, so byte 3 keeps its value
    nr(Q_MWR, 1'b1, 32'h3, 32'h77, 1'b0);
    rd(Q_RRD | Q_MWR, 1'b1, 32'h3, 32'h1234, 1'b0);
    rd(Q_MRD, 1'b1, 32'h3, 32'h77, 1'b0);

    // A second valid while busy is ignored
    nr(Q_MWR, 1'b0, 32'h20, 32'hA0B0C0D0, 1'b0);
    rd(Q_RRD, 1'b0, 32'd3, 32'h1234, 1'b0);
    drive(Q_MWR, 1'b0, 32'h20, 32'h11223344);
    rd(Q_MRD, 1'b0, 32'h20, 32'hA0B0C0D0, 1'b0);

    // Program counter: step, pause, resume, dbg_reset
    nr(Q_DBGR, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("dbgr_pc", pc, 32'h0);
    chk("dbgr_paused", {31'h0, paused}, 32'h0);
    repeat (7) @(negedge clk);
    chk("pc_7cyc", pc, 32'h0);
    @(negedge clk);
    chk("pc_8cyc", pc, 32'h4);
    nr(Q_PAUSE, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("pause_paused", {31'h0, paused}, 32'h1);
    chk("pause_pc", pc, 32'h4);
    repeat (100) @(negedge clk);
    chk("frozen_pc", pc, 32'h4);
    nr(Q_PAUSE, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("pause2_paused", {31'h0, paused}, 32'h1);
    nr(Q_RES, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("resume_paused", {31'h0, paused}, 32'h0);
    chk("resume_pc", pc, 32'h4);
    repeat (6) @(negedge clk);
    chk("run_pc_6", pc, 32'h4);
    @(negedge clk);
    chk("run_pc_7", pc, 32'h8);
    nr(Q_PAUSE, 1'b0, 32'h0, 32'h0, 1'b0);
    nr(Q_DBGR, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("dbgr2_pc", pc, 32'h0);
    chk("dbgr2_paused", {31'h0, paused}, 32'h0);

    // Reset in the middle of a busy window
    issue(Q_MRD, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cur_drd = 32'h0;
    chk("midrst_busy", {31'h0, mcu_busy}, 32'h0);
    chk("midrst_d_rd", d_rd, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    rd(Q_RRD, 1'b0, 32'd3, 32'h0, 1'b0);
    rd(Q_MRD, 1'b0, 32'h10, 32'hDEADBE55, 1'b0);

    // Reset together with valid: the write is dropped
    nr(Q_MWR, 1'b0, 32'h30, 32'h01020304, 1'b0);
    wait_idle();
    reset = 1'b1;
    drive(Q_MWR, 1'b0, 32'h30, 32'h99999999);
    reset = 1'b0;
    cur_drd = 32'h0;
    chk("rstv_busy", {31'h0, mcu_busy}, 32'h0);
    rd(Q_MRD, 1'b0, 32'h30, 32'h01020304, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
